// File: rtl/register_load_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// register_load_arbiter_pkg
//   Shared definitions for the register load arbiter and the data register it
//   drives: FSM state encodings and the polarity of the active-low LD strobe.
// ---------------------------------------------------------------------------
package register_load_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_ACK     = 2'd2,
      S_RELEASE = 2'd3
   } state_e;

   // LD strobe polarity, shared with Register
   localparam logic LD_ASSERT   = 1'b0;
   localparam logic LD_DEASSERT = 1'b1;

endpackage : register_load_arbiter_pkg

// File: rtl/Register.sv
// ---------------------------------------------------------------------------
// Register
//   Plain data register with an active-low synchronous load strobe.
//   Ports:
//     Clk   - clock, rising edge
//     Reset - asynchronous active-low reset, clears DOut
//     DIn   - data to load
//     LD    - load strobe, active low
//     DOut  - registered data
// ---------------------------------------------------------------------------
module Register
   import register_load_arbiter_pkg::*;
#(
   parameter int DataWidth = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [DataWidth-1:0] DIn,
   input  logic                 LD,
   output logic [DataWidth-1:0] DOut
);

   logic [DataWidth-1:0] data_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         data_q <= '0;
      end else if (LD == LD_ASSERT) begin
         data_q <= DIn;
      end
   end

   assign DOut = data_q;

endmodule : Register

// File: rtl/register_load_arbiter_rr_priority_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select
//   Combinational round-robin search: finds the first set request starting at
//   the priority pointer and walking upward with wrap-around.
//   Ports:
//     req_i   - per-requester request vector
//     ptr_i   - index with highest priority this round
//     found_o - at least one request is set
//     sel_o   - index of the winning requester (0 when none)
// ---------------------------------------------------------------------------
module rr_priority_select #(
   parameter int NumReq = 4
) (
   input  logic [NumReq-1:0]         req_i,
   input  logic [$clog2(NumReq)-1:0] ptr_i,
   output logic                      found_o,
   output logic [$clog2(NumReq)-1:0] sel_o
);

   localparam int PtrW = $clog2(NumReq);
   // One spare bit so ptr+offset never overflows before the wrap compare.
   localparam logic [PtrW:0] NUM_REQ_W = (PtrW + 1)'(NumReq);

   logic [PtrW:0] idx;

   always_comb begin
      found_o = 1'b0;
      sel_o   = '0;
      idx     = '0;
      for (int i = 0; i < NumReq; i++) begin
         idx = {1'b0, ptr_i} + i[PtrW:0];
         // Explicit wrap: NumReq need not be a power of two.
         if (idx >= NUM_REQ_W) begin
            idx = idx - NUM_REQ_W;
         end
         if (!found_o && req_i[idx[PtrW-1:0]]) begin
            found_o = 1'b1;
            sel_o   = idx[PtrW-1:0];
         end
      end
   end

endmodule : rr_priority_select

// File: rtl/register_load_arbiter.sv
// ---------------------------------------------------------------------------
// register_load_arbiter
//   Round-robin arbiter sharing the load port of one data register between
//   NumReq requesters. A winner is granted, its data is driven with LD low for
//   exactly one cycle, then Ack pulses for one cycle. The grant is held until
//   the requester drops Req, or released by force after TimeoutCycles cycles
//   (which sets the sticky Error flag).
//   Ports:
//     Clk   - clock, rising edge
//     Reset - asynchronous active-low reset
//     Req   - per-requester request, active high
//     DIn   - packed requester data, requester i at [i*DataWidth +: DataWidth]
//     Grant - registered one-hot grant
//     Ack   - one-cycle acknowledge after the register has loaded
//     LD    - registered active-low load strobe to the register
//     DOut  - registered data to the register
//     Busy  - arbiter is not idle
//     Error - sticky release-timeout flag
// ---------------------------------------------------------------------------
module register_load_arbiter
   import register_load_arbiter_pkg::*;
#(
   parameter int DataWidth     = 16,
   parameter int NumReq        = 4,
   parameter int TimeoutCycles = 15
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [NumReq-1:0]           Req,
   input  logic [NumReq*DataWidth-1:0] DIn,
   output logic [NumReq-1:0]           Grant,
   output logic [NumReq-1:0]           Ack,
   output logic                        LD,
   output logic [DataWidth-1:0]        DOut,
   output logic                        Busy,
   output logic                        Error
);

   localparam int PtrW = $clog2(NumReq);
   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [PtrW-1:0] PTR_LAST = PtrW'(NumReq - 1);
   localparam logic [CntW-1:0] CNT_LAST = CntW'(TimeoutCycles - 1);

   state_e               state_q, state_d;
   logic [PtrW-1:0]      sel_q,   sel_d;
   logic [PtrW-1:0]      ptr_q,   ptr_d;
   logic [CntW-1:0]      cnt_q,   cnt_d;
   logic [NumReq-1:0]    grant_q, grant_d;
   logic [NumReq-1:0]    ack_q,   ack_d;
   logic                 ld_q,    ld_d;
   logic [DataWidth-1:0] dout_q,  dout_d;
   logic                 error_q, error_d;

   logic                 rr_found;
   logic [PtrW-1:0]      rr_sel;
   logic [DataWidth-1:0] din_arr [NumReq];

   for (genvar g = 0; g < NumReq; g++) begin : g_din
      assign din_arr[g] = DIn[g*DataWidth +: DataWidth];
   end

   rr_priority_select #(
      .NumReq(NumReq)
   ) u_rr_sel (
      .req_i   (Req),
      .ptr_i   (ptr_q),
      .found_o (rr_found),
      .sel_o   (rr_sel)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         ld_q    <= LD_DEASSERT;
         dout_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         ld_q    <= ld_d;
         dout_q  <= dout_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      ack_d   = ack_q;
      ld_d    = ld_q;
      dout_d  = dout_q;
      error_d = error_q;

      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               // Data is captured here; later DIn changes cannot reach DOut.
               sel_d          = rr_sel;
               grant_d        = '0;
               grant_d[rr_sel] = 1'b1;
               dout_d         = din_arr[rr_sel];
               ld_d           = LD_ASSERT;
               state_d        = S_LOAD;
            end
         end
         S_LOAD: begin
            // Register captures DOut at this edge; Ack follows with LD high.
            ld_d          = LD_DEASSERT;
            ack_d         = '0;
            ack_d[sel_q]  = 1'b1;
            state_d       = S_ACK;
         end
         S_ACK: begin
            ack_d   = '0;
            ptr_d   = (sel_q == PTR_LAST) ? '0 : sel_q + 1'b1;
            cnt_d   = '0;
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!Req[sel_q]) begin
               grant_d = '0;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               grant_d = '0;
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign Grant = grant_q;
   assign Ack   = ack_q;
   assign LD    = ld_q;
   assign DOut  = dout_q;
   assign Busy  = (state_q != S_IDLE);
   assign Error = error_q;

endmodule : register_load_arbiter

// File: tb/tb_register_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_register_load_arbiter
//   Directed bench: arbiter driving a Register, expected values hand-computed.
// ---------------------------------------------------------------------------
module tb_register_load_arbiter;

   localparam int DW = 16;
   localparam int NR = 4;
   localparam int TO = 15;

   logic             Clk = 1'b0;
   logic             Reset;
   logic [NR-1:0]    Req;
   logic [NR*DW-1:0] DIn;
   logic [NR-1:0]    Grant;
   logic [NR-1:0]    Ack;
   logic             LD;
   logic [DW-1:0]    DOut;
   logic             Busy;
   logic             Error;
   logic [DW-1:0]    reg_q;

   int ncmp = 0;
   int nerr = 0;

   always #5 Clk = ~Clk;

   register_load_arbiter #(
      .DataWidth     (DW),
      .NumReq        (NR),
      .TimeoutCycles (TO)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Req   (Req),
      .DIn   (DIn),
      .Grant (Grant),
      .Ack   (Ack),
      .LD    (LD),
      .DOut  (DOut),
      .Busy  (Busy),
      .Error (Error)
   );

   Register #(.DataWidth(DW)) u_reg (
      .Clk   (Clk),
      .Reset (Reset),
      .DIn   (DOut),
      .LD    (LD),
      .DOut  (reg_q)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic set_din(input int i, input logic [DW-1:0] v);
      DIn[i*DW +: DW] = v;
   endtask

   // One full transaction starting from an IDLE negedge with Req already set.
   // The granted requester drops Req once in S_RELEASE.
   task automatic do_txn(input logic [NR-1:0] g, input logic [DW-1:0] d);
      step(1);
      chk("txn_grant", 32'(Grant), 32'(g));
      chk("txn_ld_low", 32'(LD), 32'd0);
      step(1);
      chk("txn_ack", 32'(Ack), 32'(g));
      chk("txn_ld_high", 32'(LD), 32'd1);
      chk("txn_reg", 32'(reg_q), 32'(d));
      step(1);
      chk("txn_ack_clr", 32'(Ack), 32'd0);
      Req = Req & ~g;
      step(1);
      chk("txn_idle", 32'(Busy), 32'd0);
      chk("txn_grant_clr", 32'(Grant), 32'd0);
   endtask

   // Per-cycle invariants while out of reset.
   always @(negedge Clk) begin
      if (Reset === 1'b1) begin
         chk("inv_grant_onehot0", 32'($onehot0(Grant)), 32'd1);
         chk("inv_ack_during_ld", 32'((LD == 1'b0) && (Ack != '0)), 32'd0);
      end
   end

   initial begin
      Reset = 1'b1;
      Req   = '0;
      DIn   = '0;
      #2 Reset = 1'b0;

      // Reset state
      step(2);
      chk("rst_grant", 32'(Grant), 32'd0);
      chk("rst_ack",   32'(Ack),   32'd0);
      chk("rst_ld",    32'(LD),    32'd1);
      chk("rst_dout",  32'(DOut),  32'd0);
      chk("rst_busy",  32'(Busy),  32'd0);
      chk("rst_error", 32'(Error), 32'd0);
      step(3);
      Reset = 1'b1;

      // Idle with no requests
      step(10);
      chk("idle_ld",    32'(LD),    32'd1);
      chk("idle_grant", 32'(Grant), 32'd0);
      chk("idle_busy",  32'(Busy),  32'd0);
      chk("idle_dout",  32'(DOut),  32'd0);
      chk("idle_reg",   32'(reg_q), 32'd0);

      // Single request from requester 1
      set_din(1, 16'h00A0);
      set_din(3, 16'h3333);
      Req = 4'b0010;
      step(1);
      chk("single_grant", 32'(Grant), 32'h2);
      chk("single_ld",    32'(LD),    32'd0);
      chk("single_dout",  32'(DOut),  32'h00A0);
      chk("single_busy",  32'(Busy),  32'd1);
      // Data change after grant and a competing request must not interfere.
      set_din(1, 16'hBEEF);
      Req = 4'b1010;
      step(1);
      chk("single_ack",     32'(Ack),   32'h2);
      chk("single_ld_hi",   32'(LD),    32'd1);
      chk("single_reg",     32'(reg_q), 32'h00A0);
      chk("single_dout_st", 32'(DOut),  32'h00A0);
      chk("single_grant_h", 32'(Grant), 32'h2);
      step(1);
      chk("single_ack_clr", 32'(Ack),   32'd0);
      chk("single_rel_gnt", 32'(Grant), 32'h2);
      chk("single_rel_busy", 32'(Busy), 32'd1);
      Req = 4'b1000;
      step(1);
      chk("single_done_busy", 32'(Busy),  32'd0);
      chk("single_done_gnt",  32'(Grant), 32'd0);
      chk("single_done_reg",  32'(reg_q), 32'h00A0);

      // Requester 3 now wins; reset lands while LD is low.
      step(1);
      chk("midrst_grant", 32'(Grant), 32'h8);
      chk("midrst_ld",    32'(LD),    32'd0);
      chk("midrst_dout",  32'(DOut),  32'h3333);
      Reset = 1'b0;
      #1;
      chk("midrst_ld_after",   32'(LD),    32'd1);
      chk("midrst_grant_aft",  32'(Grant), 32'd0);
      chk("midrst_ack_aft",    32'(Ack),   32'd0);
      chk("midrst_busy_aft",   32'(Busy),  32'd0);
      chk("midrst_dout_aft",   32'(DOut),  32'd0);
      chk("midrst_reg_aft",    32'(reg_q), 32'd0);
      Req = '0;
      step(1);
      Reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(1);
         chk("midrst_no_ack", 32'(Ack),   32'd0);
         chk("midrst_reg",    32'(reg_q), 32'd0);
      end

      // Round-robin fairness from pointer 0
      for (int i = 0; i < NR; i++) set_din(i, 16'h0010 + 16'(i));
      Req = 4'b1111;
      do_txn(4'b0001, 16'h0010);
      Req = 4'b1111;
      do_txn(4'b0010, 16'h0011);
      Req = 4'b1111;
      do_txn(4'b0100, 16'h0012);
      Req = 4'b1111;
      do_txn(4'b1000, 16'h0013);
      Req = 4'b1111;
      do_txn(4'b0001, 16'h0010);

      // Wrap and skip: serve 2 (pointer -> 3), then 0 before 2
      Req = 4'b0100;
      do_txn(4'b0100, 16'h0012);
      Req = 4'b0101;
      do_txn(4'b0001, 16'h0010);
      do_txn(4'b0100, 16'h0012);

      // Release timeout on requester 2
      Req = 4'b0100;
      step(1);
      chk("to_grant", 32'(Grant), 32'h4);
      step(1);
      chk("to_ack", 32'(Ack), 32'h4);
      step(1);
      chk("to_rel_grant", 32'(Grant), 32'h4);
      step(TO - 1);
      chk("to_hold_grant", 32'(Grant), 32'h4);
      chk("to_hold_error", 32'(Error), 32'd0);
      chk("to_hold_busy",  32'(Busy),  32'd1);
      step(1);
      chk("to_drop_grant", 32'(Grant), 32'd0);
      chk("to_error",      32'(Error), 32'd1);
      chk("to_busy",       32'(Busy),  32'd0);
      Req = '0;

      // Error stays set through a good transaction, clears only on reset.
      Req = 4'b0010;
      do_txn(4'b0010, 16'h0011);
      chk("to_error_sticky", 32'(Error), 32'd1);
      Reset = 1'b0;
      #1;
      chk("to_error_reset", 32'(Error), 32'd0);
      step(1);
      Reset = 1'b1;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule : tb_register_load_arbiter
